// File: rtl/rv32_pkg.sv
// RV32 instruction format enum, opcode constants and encoder helpers shared by the
// instruction-injection path.
package rv32_pkg;

   typedef enum logic [2:0] {
      FMT_R      = 3'd0,
      FMT_I      = 3'd1,
      FMT_S      = 3'd2,
      FMT_U      = 3'd3,
      FMT_B      = 3'd4,
      FMT_J      = 3'd5,
      FMT_SYSTEM = 3'd6
   } inst_fmt_t;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam int INST_W = 32;

   typedef struct packed {
      logic              err;
      logic [INST_W-1:0] inst;
   } enc_word_t;

   // True when v is a sign-extension of its low 'bits' bits.
   function automatic logic fits_signed(input logic [31:0] v, input int bits);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i >= bits - 1 && v[i] != v[bits-1]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO, registered head; rd_dat reads 0 while empty.
// Latency 1 cycle push->visible; push ignored when full, pop ignored when empty.
// Synchronous active-low reset empties the queue.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_dat,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             wr_en;
   logic             rd_en;

   assign full   = (cnt == (AW+1)'(DEPTH));
   assign empty  = (cnt == '0);
   assign wr_en  = push && !full;
   assign rd_en  = pop && !empty;
   assign rd_dat = empty ? '0 : mem[rd_ptr];

   // Storage needs no reset: the head is masked by empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !rd_en)      cnt <= cnt + (AW+1)'(1);
         else if (rd_en && !wr_en) cnt <= cnt - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/inst_encode_stream.sv
// Packs decoded RV32 fields into instruction words; legality checks when ENCODE_CHECK_EN is defined.
// Latency: bundle accepted in cycle N appears at out_* in N+1 when the queue was empty.
// Backpressure: in_ready = queue not full; no same-cycle bypass when full.
module inst_encode_stream
   import rv32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err,
   output logic [15:0] err_count
);

   inst_fmt_t         fmt;
   logic [INST_W-1:0] enc_inst;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;

   assign fmt       = inst_fmt_t'(in_fmt);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Unknown formats fall through to R packing.
   always_comb begin
      enc_inst = '0;
      case (fmt)
         FMT_I:      enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S:      enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B:      enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
         FMT_U:      enc_inst = {in_imm[31:12], in_rd, in_opcode};
         FMT_J:      enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
         FMT_SYSTEM: enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         default:    enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      endcase
   end

`ifdef ENCODE_CHECK_EN
   localparam int FW = INST_W + 1;

   logic      opc_err;
   logic      fmt_err;
   logic      enc_err;
   enc_word_t wr_word;
   enc_word_t rd_word;

   assign opc_err = (in_opcode[1:0] != 2'b11);
   assign enc_err = opc_err || fmt_err;

   always_comb begin
      fmt_err = 1'b0;
      case (fmt)
         FMT_R:          fmt_err = 1'b0;
         FMT_I, FMT_S:   fmt_err = !fits_signed(in_imm, 12);
         FMT_B:          fmt_err = !fits_signed(in_imm, 13) || in_imm[0];
         FMT_J:          fmt_err = !fits_signed(in_imm, 21) || in_imm[0];
         FMT_U:          fmt_err = |in_imm[11:0];
         FMT_SYSTEM:     fmt_err = |in_imm[31:12];
         default:        fmt_err = 1'b1;
      endcase
   end

   assign wr_word = '{err: enc_err, inst: enc_inst};

   sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .pop    (pop),
      .wr_dat (wr_word),
      .rd_dat (rd_word),
      .full   (full),
      .empty  (empty)
   );

   assign out_inst = rd_word.inst;
   assign out_err  = rd_word.err;

   // Counts accepted erroneous bundles, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (push && enc_err && err_count != 16'hFFFF) begin
         err_count <= err_count + 16'd1;
      end
   end
`else
   logic [INST_W-1:0] rd_inst;

   sync_fifo #(.WIDTH(INST_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .pop    (pop),
      .wr_dat (enc_inst),
      .rd_dat (rd_inst),
      .full   (full),
      .empty  (empty)
   );

   assign out_inst  = rd_inst;
   assign out_err   = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_inst_encode_stream.sv
// Directed bench for inst_encode_stream; expectations adapt to whether ENCODE_CHECK_EN is defined.
module tb_inst_encode_stream;
   import rv32_pkg::*;

`ifdef ENCODE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp;
      logic        bad;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [15:0] err_count;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_errcnt = 16'd0;
   vec_t        tbl [17];

   inst_encode_stream #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic init_table();
      //            fmt         opc    rd    rs1   rs2   f3    f7     imm            exp           bad
      tbl[0]  = '{FMT_I,      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 32'h00500093, 1'b0};
      tbl[1]  = '{FMT_S,      7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'h00, 32'h00000008, 32'h0021A423, 1'b0};
      tbl[2]  = '{FMT_J,      7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFFDFF0EF, 1'b0};
      tbl[3]  = '{FMT_U,      7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
      tbl[4]  = '{FMT_R,      7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 32'h402081B3, 1'b0};
      tbl[5]  = '{FMT_SYSTEM, 7'h73, 5'd2, 5'd1, 5'd31,3'd1, 7'h7F, 32'h00000300, 32'h30009173, 1'b0};
      tbl[6]  = '{FMT_B,      7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0};
      tbl[7]  = '{FMT_B,      7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 32'h00208163, 1'b1};
      tbl[8]  = '{FMT_I,      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1};
      tbl[9]  = '{FMT_I,      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
      tbl[10] = '{FMT_I,      7'h10, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 32'h00500090, 1'b1};
      tbl[11] = '{3'd7,       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 32'h002081B3, 1'b1};
      tbl[12] = '{FMT_U,      7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h123452B7, 1'b1};
      tbl[13] = '{FMT_SYSTEM, 7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h00000073, 1'b1};
      tbl[14] = '{FMT_J,      7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b1};
      tbl[15] = '{FMT_B,      7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h80000063, 1'b1};
      tbl[16] = '{FMT_S,      7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'hFFFFF800, 32'h80002023, 1'b0};
   endtask

   task automatic set_fields(input vec_t v);
      in_fmt    = v.fmt;
      in_opcode = v.opc;
      in_rd     = v.rd;
      in_rs1    = v.rs1;
      in_rs2    = v.rs2;
      in_funct3 = v.f3;
      in_funct7 = v.f7;
      in_imm    = v.imm;
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic push_bundle(input vec_t v);
      int waited;
      set_fields(v);
      in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL push_timeout in_ready=%0b required=1 within 50 cycles", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (CHK && v.bad) exp_errcnt = exp_errcnt + 16'd1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      set_fields(tbl[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL rst_out_inst got=%h exp=00000000", out_inst); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%0b exp=0", out_err); end
      checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Each vector alone: visible the cycle after accept, then drained.
   task automatic test_packing();
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         push_bundle(tbl[k]);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack%0d_valid got=%0b exp=1", k, out_valid); end
         checks++; if (out_inst !== tbl[k].exp) begin failures++; $display("FAIL pack%0d_inst got=%h exp=%h", k, out_inst, tbl[k].exp); end
         checks++; if (out_err !== (CHK & tbl[k].bad)) begin failures++; $display("FAIL pack%0d_err got=%0b exp=%0b", k, out_err, CHK & tbl[k].bad); end
         checks++; if (err_count !== exp_errcnt) begin failures++; $display("FAIL pack%0d_errcnt got=%0d exp=%0d", k, err_count, exp_errcnt); end
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack%0d_drained got=%0b exp=0", k, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_fields(tbl[k]);
         in_valid = 1'b1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready got=%0b exp=1", k, in_ready); end
         @(posedge clk);
         @(negedge clk);
         checks++; if (out_inst !== tbl[k].exp) begin failures++; $display("FAIL b2b%0d_inst got=%h exp=%h", k, out_inst, tbl[k].exp); end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic acc;
      logic accepted5;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_bundle(tbl[k]);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
      set_fields(tbl[4]);
      in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready got=%0b exp=0", in_ready); end
      out_ready = 1'b1;
      accepted5 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_bypass in_ready=%0b exp=0", in_ready); end
         end
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain%0d_valid got=%0b exp=1", k, out_valid); end
         checks++; if (out_inst !== tbl[k].exp) begin failures++; $display("FAIL bp_drain%0d_inst got=%h exp=%h", k, out_inst, tbl[k].exp); end
         acc = in_valid && in_ready;
         @(posedge clk);
         @(negedge clk);
         if (acc) begin
            in_valid = 1'b0;
            accepted5 = 1'b1;
         end
      end
      checks++; if (accepted5 !== 1'b1) begin failures++; $display("FAIL bp_fifth_accepted got=%0b exp=1", accepted5); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      push_bundle(tbl[7]);
      push_bundle(tbl[0]);
      checks++; if (err_count !== exp_errcnt) begin failures++; $display("FAIL mid_errcnt_pre got=%0d exp=%0d", err_count, exp_errcnt); end
      checks++; if (out_inst !== tbl[7].exp) begin failures++; $display("FAIL mid_head_pre got=%h exp=%h", out_inst, tbl[7].exp); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_errcnt = 16'd0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL mid_out_inst got=%h exp=00000000", out_inst); end
      checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL mid_err_count got=%0d exp=0", err_count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale got=%0b exp=0", out_valid); end
   endtask

   initial begin
      init_table();
      test_reset();
      test_packing();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
